// File: rtl/rx_pixel_writer.sv
// Pixel writer between the CC1200 receive path and frame memory: FIFO-buffered,
// double-banked addressed writes with line/frame bookkeeping and sticky errors.
module rx_pixel_writer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int LINE_PIX   = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FrameSync,
  input  logic              LineSync,
  input  logic [DATA_W-1:0] RxData,
  input  logic              RxValid,
  input  logic [ADDR_W-1:0] RxAdd,
  input  logic              RxAddValid,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              wr_bank,
  output logic              frame_done,
  output logic [15:0]       line_count,
  output logic              line_pix_err,
  output logic              overflow,
  input  logic              err_clr
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic {WAIT_FRAME, IN_FRAME} state_t;

  state_t               state, stateNext;
  logic [ADDR_W-1:0]    curAddr, curAddrNext, pixAddr;
  logic [15:0]          lineCntNext, pixCnt, pixCntNext;
  logic                 bankNext, frameDoneNext, lineErrSet, pushReq, active;

  logic [ENTRY_W-1:0]   fifoMem [FIFO_DEPTH];
  logic [PTR_W:0]       rdPtr, wrPtr;
  logic                 fifoEmpty, fifoFull, doPush, doPop, dropPix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= stateNext;
  end

  // Same-cycle events apply in order FrameSync -> RxAddValid/LineSync -> RxValid,
  // each stage working on the values left by the previous one.
  always_comb begin
    stateNext     = state;
    bankNext      = wr_bank;
    curAddrNext   = curAddr;
    lineCntNext   = line_count;
    pixCntNext    = pixCnt;
    frameDoneNext = 1'b0;
    lineErrSet    = 1'b0;
    pushReq       = 1'b0;
    active        = (state == IN_FRAME);
    if (FrameSync) begin
      if (state == IN_FRAME) begin
        bankNext      = ~wr_bank;
        frameDoneNext = 1'b1;
      end
      stateNext   = IN_FRAME;
      curAddrNext = '0;
      lineCntNext = '0;
      pixCntNext  = '0;
      active      = 1'b1;
    end
    pixAddr = RxAddValid ? RxAdd : curAddrNext;
    if (active) begin
      if (LineSync) begin
        if (pixCntNext != '0 && pixCntNext != 16'(LINE_PIX)) lineErrSet = 1'b1;
        if (lineCntNext != '1) lineCntNext = lineCntNext + 16'd1;
        pixCntNext = '0;
      end
      if (RxValid) begin
        pushReq     = 1'b1;
        curAddrNext = pixAddr + ADDR_W'(1);
        if (pixCntNext != '1) pixCntNext = pixCntNext + 16'd1;
      end else begin
        curAddrNext = pixAddr;
      end
    end
  end

  assign fifoEmpty = (rdPtr == wrPtr);
  assign fifoFull  = (rdPtr[PTR_W] != wrPtr[PTR_W]) &&
                     (rdPtr[PTR_W-1:0] == wrPtr[PTR_W-1:0]);
  assign doPop     = !fifoEmpty && mem_ready;
  assign doPush    = pushReq && (!fifoFull || doPop);
  assign dropPix   = pushReq && !doPush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curAddr      <= '0;
      line_count   <= '0;
      pixCnt       <= '0;
      wr_bank      <= 1'b0;
      frame_done   <= 1'b0;
      line_pix_err <= 1'b0;
      overflow     <= 1'b0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
    end else begin
      curAddr      <= curAddrNext;
      line_count   <= lineCntNext;
      pixCnt       <= pixCntNext;
      wr_bank      <= bankNext;
      frame_done   <= frameDoneNext;
      line_pix_err <= lineErrSet | (line_pix_err & ~err_clr);
      overflow     <= dropPix | (overflow & ~err_clr);
      if (doPop) rdPtr <= rdPtr + (PTR_W+1)'(1);
      if (doPush) begin
        fifoMem[wrPtr[PTR_W-1:0]] <= {bankNext, pixAddr, RxData};
        wrPtr <= wrPtr + (PTR_W+1)'(1);
      end
    end
  end

  assign mem_we                = !fifoEmpty;
  assign {mem_addr, mem_wdata} = fifoMem[rdPtr[PTR_W-1:0]];

endmodule
